fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/skid_buf3.sv | 45 ++++
 rtl/fifo_rd_stream.sv | 63 ++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream read adapter.
// Buffer depth, occupancy type and pointer helper.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry first-in first-out output buffer.
// The head entry is always presented on head_data.
module skid_buf3
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Reads a registered-output FIFO and presents it as a packetised
// valid/ready stream, with a 3-entry buffer absorbing read latency.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic          inflight;
  occ_t          occ;
  logic [2:0]    pend;
  logic [BW-1:0] beat;
  logic          hs;

  // Reserve a slot for every read whose data has not yet landed.
  assign pend = {1'b0, occ} + {2'b00, inflight};

  assign fifo_rd_en_o = rst_n & enable_i & ~fifo_empty_i
                      & (pend < 3'(BUF_DEPTH));

  assign m_valid_o = (occ != 2'd0);
  assign hs        = m_valid_o & m_ready_i;
  assign m_last_o  = m_valid_o & (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= fifo_rd_en_o;
      if (hs)
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

  skid_buf3 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(fifo_data_i),
    .pop      (hs),
    .occ      (occ),
    .head_data(m_data_o)
  );

endmodule
